// File: rtl/fib_index.sv
// Inverse Fibonacci engine: finds the largest n with F(n) <= value, reporting n, F(n) and exactness.
// Optional FIB_INDEX_REMAINDER_EN adds the registered o_rem = value - F(n) output.
module fib_index #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_stb,
  output logic             o_busy,
  input  logic [WIDTH-1:0] i_value,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_n,
  output logic [WIDTH-1:0] o_fib,
  output logic             o_exact
`ifdef FIB_INDEX_REMAINDER_EN
  ,
  output logic [WIDTH-1:0] o_rem
`endif
);

  typedef enum logic [0:0] {
    StIdle,
    StSearch
  } state_e;

  localparam logic [WIDTH-1:0] One  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] Zero = '0;

  state_e           r_state, w_state_next;
  logic [WIDTH-1:0] r_target, w_target_next;
  logic [WIDTH-1:0] r_prev, w_prev_next;
  logic [WIDTH-1:0] r_cur, w_cur_next;
  logic [WIDTH-1:0] r_n, w_n_next;
  logic             r_valid, w_valid_next;
  logic [WIDTH-1:0] r_res_n, w_res_n_next;
  logic [WIDTH-1:0] r_res_fib, w_res_fib_next;
  logic             r_res_exact, w_res_exact_next;

  // A carry out of the sum means the next term exceeds any WIDTH-bit target.
  logic [WIDTH:0]   w_sum;
  logic             w_step;

  assign w_sum  = {1'b0, r_prev} + {1'b0, r_cur};
  assign w_step = ~w_sum[WIDTH] && (w_sum[WIDTH-1:0] <= r_target);

`ifdef FIB_INDEX_REMAINDER_EN
  logic [WIDTH-1:0] r_res_rem, w_res_rem_next;
`endif

  always_comb begin
    w_state_next     = r_state;
    w_target_next    = r_target;
    w_prev_next      = r_prev;
    w_cur_next       = r_cur;
    w_n_next         = r_n;
    w_valid_next     = 1'b0;
    w_res_n_next     = r_res_n;
    w_res_fib_next   = r_res_fib;
    w_res_exact_next = r_res_exact;
`ifdef FIB_INDEX_REMAINDER_EN
    w_res_rem_next   = r_res_rem;
`endif
    unique case (r_state)
      StIdle: begin
        if (i_stb) begin
          w_target_next = i_value;
          w_prev_next   = One;
          w_cur_next    = Zero;
          w_n_next      = Zero;
          w_state_next  = StSearch;
        end
      end
      StSearch: begin
        if (w_step) begin
          w_cur_next  = w_sum[WIDTH-1:0];
          w_prev_next = r_cur;
          w_n_next    = r_n + One;
        end else begin
          w_res_n_next     = r_n;
          w_res_fib_next   = r_cur;
          w_res_exact_next = (r_cur == r_target);
`ifdef FIB_INDEX_REMAINDER_EN
          w_res_rem_next   = r_target - r_cur;
`endif
          w_valid_next     = 1'b1;
          w_state_next     = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state     <= StIdle;
      r_target    <= Zero;
      r_prev      <= One;
      r_cur       <= Zero;
      r_n         <= Zero;
      r_valid     <= 1'b0;
      r_res_n     <= Zero;
      r_res_fib   <= Zero;
      r_res_exact <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_target    <= w_target_next;
      r_prev      <= w_prev_next;
      r_cur       <= w_cur_next;
      r_n         <= w_n_next;
      r_valid     <= w_valid_next;
      r_res_n     <= w_res_n_next;
      r_res_fib   <= w_res_fib_next;
      r_res_exact <= w_res_exact_next;
    end
  end

`ifdef FIB_INDEX_REMAINDER_EN
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_res_rem <= Zero;
    end else begin
      r_res_rem <= w_res_rem_next;
    end
  end

  assign o_rem = r_res_rem;
`endif

  assign o_busy  = (r_state == StSearch);
  assign o_valid = r_valid;
  assign o_n     = r_res_n;
  assign o_fib   = r_res_fib;
  assign o_exact = r_res_exact;

endmodule

// File: tb/tb_fib_index.sv
// Randomized self-checking bench for fib_index against a Fibonacci-table reference model.
// Honors FIB_INDEX_REMAINDER_EN when the design is built with it.
module tb_fib_index;

  localparam int unsigned WIDTH = 32;

  logic             clk;
  logic             reset_n;
  logic             stb;
  logic             busy;
  logic [WIDTH-1:0] value;
  logic             valid;
  logic [WIDTH-1:0] res_n;
  logic [WIDTH-1:0] res_fib;
  logic             exact;
`ifdef FIB_INDEX_REMAINDER_EN
  logic [WIDTH-1:0] rem;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  longint unsigned fib_tab[0:63];

  fib_index #(.WIDTH(WIDTH)) u_dut (
    .i_clk    (clk),
    .i_reset_n(reset_n),
    .i_stb    (stb),
    .o_busy   (busy),
    .i_value  (value),
    .o_valid  (valid),
    .o_n      (res_n),
    .o_fib    (res_fib),
    .o_exact  (exact)
`ifdef FIB_INDEX_REMAINDER_EN
    ,
    .o_rem    (rem)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input longint unsigned got,
                           input longint unsigned exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Largest table index whose Fibonacci number does not exceed v.
  function automatic int ref_index(input longint unsigned v);
    int idx = 0;
    for (int i = 0; i < 64; i++) if (fib_tab[i] <= v) idx = i;
    return idx;
  endfunction

  // Drive a request now; it is accepted at the next rising edge (DUT must be idle there).
  task automatic do_accept(input logic [WIDTH-1:0] v);
    value = v;
    stb   = 1'b1;
    @(posedge clk);
    #1;
    stb = 1'b0;
    check_val("busy_after_accept", busy, 1);
  endtask

  // Wait for completion after an accept edge; optionally pulse stb mid-search.
  task automatic wait_result(input logic [WIDTH-1:0] v, input bit inject);
    int lat = 0;
    int exp_n;
    exp_n = ref_index(longint'(v));
    while (!valid && lat < 200) begin
      if (inject && lat == 3) begin
        value = v ^ 32'h5;
        stb   = 1'b1;
      end
      @(posedge clk);
      #1;
      stb = 1'b0;
      lat++;
    end
    check_val("latency", lat, exp_n + 1);
    check_val("o_n", res_n, exp_n);
    check_val("o_fib", res_fib, fib_tab[exp_n]);
    check_val("o_exact", exact, (fib_tab[exp_n] == longint'(v)) ? 1 : 0);
`ifdef FIB_INDEX_REMAINDER_EN
    check_val("o_rem", rem, longint'(v) - fib_tab[exp_n]);
`endif
    check_val("busy_at_valid", busy, 0);
  endtask

  task automatic run_req(input logic [WIDTH-1:0] v, input bit inject);
    @(negedge clk);
    do_accept(v);
    wait_result(v, inject);
    @(posedge clk);
    #1;
    check_val("valid_one_cycle", valid, 0);
    check_val("o_n_hold", res_n, ref_index(longint'(v)));
  endtask

  initial begin
    logic [WIDTH-1:0] rv;
    fib_tab[0] = 0;
    fib_tab[1] = 1;
    for (int i = 2; i < 64; i++) fib_tab[i] = fib_tab[i-1] + fib_tab[i-2];

    reset_n = 1'b0;
    stb     = 1'b0;
    value   = '0;
    #1;
    check_val("rst_busy", busy, 0);
    check_val("rst_valid", valid, 0);
    check_val("rst_n", res_n, 0);
    check_val("rst_fib", res_fib, 0);
    check_val("rst_exact", exact, 0);
`ifdef FIB_INDEX_REMAINDER_EN
    check_val("rst_rem", rem, 0);
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    run_req(32'd0, 1'b0);
    run_req(32'd1, 1'b0);
    run_req(32'd5, 1'b0);
    run_req(32'd100, 1'b1);
    run_req(32'hFFFF_FFFF, 1'b0);

    // Back-to-back: second request held during the o_valid cycle.
    @(negedge clk);
    do_accept(32'd8);
    wait_result(32'd8, 1'b0);
    do_accept(32'd13);
    wait_result(32'd13, 1'b0);
    @(posedge clk);
    #1;
    check_val("b2b_valid_drop", valid, 0);

    // Asynchronous reset mid-search of 1000.
    @(negedge clk);
    do_accept(32'd1000);
    repeat (4) @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check_val("abort_busy", busy, 0);
    check_val("abort_valid", valid, 0);
    check_val("abort_n", res_n, 0);
    check_val("abort_fib", res_fib, 0);
    check_val("abort_exact", exact, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    begin
      int seen = 0;
      for (int i = 0; i < 20; i++) begin
        @(posedge clk);
        #1;
        if (valid) seen++;
      end
      check_val("abort_no_valid", seen, 0);
    end
    run_req(32'd21, 1'b0);

    // Random targets: wide, small, and Fibonacci numbers with small offsets.
    for (int i = 0; i < 40; i++) begin
      unique case (i % 3)
        0: rv = $urandom;
        1: rv = $urandom_range(0, 2000);
        default: rv = 32'(fib_tab[$urandom_range(0, 47)]) + 32'($urandom_range(0, 2)) - 32'd1;
      endcase
      run_req(rv, ($urandom_range(0, 3) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
